// File: rtl/spi_master_ctrl.sv
// SPI master frame generator: turns one {cmd, data} request into one complete
// slave frame and, for read-data requests, captures the byte returned on MISO.
module spi_master_ctrl #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int FW = DATA_W + 2;
  localparam int CW = $clog2(FW + RD_LAT + DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, CMD, SHIFT, WAIT_RD, CAPTURE, RELEASE
  } state_t;

  state_t            state;
  logic [FW-1:0]     frame;
  logic [1:0]        cmd_q;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-2:0] shreg;

  // Every output is set on entry to the state it belongs to, so each state's
  // values appear exactly during the cycles that state occupies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      frame   <= '0;
      cmd_q   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= '0;
      SS_n    <= 1'b1;
      MOSI    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          SS_n <= 1'b1;
          if (start) begin
            frame <= {cmd, data_in};
            cmd_q <= cmd;
            state <= SELECT;
            SS_n  <= 1'b0;
            busy  <= 1'b1;
            MOSI  <= 1'b0;
          end
        end
        SELECT: begin
          MOSI  <= cmd_q[1];
          state <= CMD;
        end
        CMD: begin
          MOSI    <= frame[FW-1];
          frame   <= {frame[FW-2:0], 1'b0};
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        // The frame register shifts left so the next MSB is always at the top.
        SHIFT: begin
          if (bit_cnt == CW'(FW - 1)) begin
            MOSI    <= 1'b0;
            bit_cnt <= '0;
            if (cmd_q == 2'b11) begin
              state <= WAIT_RD;
            end else begin
              state <= RELEASE;
              SS_n  <= 1'b1;
              done  <= 1'b1;
            end
          end else begin
            MOSI    <= frame[FW-1];
            frame   <= {frame[FW-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        WAIT_RD: begin
          if (bit_cnt == CW'(RD_LAT - 1)) begin
            bit_cnt <= '0;
            state   <= CAPTURE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        // Only DATA_W-1 bits are buffered; the last MISO bit goes straight into rd_data.
        CAPTURE: begin
          shreg <= (DATA_W - 1)'({shreg, MISO});
          if (bit_cnt == CW'(DATA_W - 1)) begin
            rd_data <= {shreg, MISO};
            state   <= RELEASE;
            SS_n    <= 1'b1;
            done    <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomised scoreboard bench for spi_master_ctrl with a behavioural MISO stub
// and a frame-level reference model.
module tb_spi_master_ctrl;

  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [1:0]        cmd;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_data;
  logic              SS_n;
  logic              MOSI;
  logic              MISO;

  typedef struct {
    int                accept;
    logic [1:0]        c;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] rdExp;
  } frame_t;

  frame_t sb[$];

  int assertions = 0;
  int failures   = 0;
  int cycle      = 0;

  logic [DATA_W-1:0] modelRd = '0;
  logic              stubActive = 1'b0;
  int                stubAccept = 0;
  logic [DATA_W-1:0] stubByte = '0;

  spi_master_ctrl #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .data_in(data_in),
    .busy(busy), .done(done), .rd_data(rd_data), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Frame length from accept edge to done pulse.
  function automatic int expLen(input logic [1:0] c);
    return (c == 2'b11) ? DATA_W + 4 + RD_LAT + DATA_W : DATA_W + 4;
  endfunction

  // Expected MOSI k cycles after the accept edge: select gap, command bit, then the frame MSB first.
  function automatic logic expMosi(input logic [1:0] c, input logic [DATA_W-1:0] d, input int k);
    logic [DATA_W+1:0] f;
    f = {c, d};
    if (k == 0) return 1'b0;
    if (k == 1) return c[1];
    return f[DATA_W + 3 - k];
  endfunction

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Slave stub: the returned byte starts RD_LAT cycles after the last MOSI bit; junk elsewhere.
  always @(negedge clk) begin
    int k;
    k = cycle - stubAccept;
    if (stubActive && k >= DATA_W + 4 + RD_LAT && k < DATA_W + 4 + RD_LAT + DATA_W)
      MISO = stubByte[DATA_W - 1 - (k - (DATA_W + 4 + RD_LAT))];
    else
      MISO = 1'($urandom);
  end

  // Monitor: follows the frame at the head of the scoreboard and judges it on done.
  int mosiErr = 0;
  int glitch  = 0;
  always @(negedge clk) begin
    int k;
    int len;
    k = 0;
    len = 0;
    if (!rst_n) begin
      mosiErr = 0;
      glitch  = 0;
    end else begin
      if (sb.size() > 0) begin
        k   = cycle - sb[0].accept;
        len = expLen(sb[0].c);
        if (k >= 0 && k < len) begin
          if (SS_n !== 1'b0 || busy !== 1'b1 || done !== 1'b0) glitch++;
          if (k <= DATA_W + 3 && MOSI !== expMosi(sb[0].c, sb[0].d, k)) mosiErr++;
        end
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_done", 32'(done), 0);
        end else begin
          checkOutput("latency", k, len);
          checkOutput("mosi_bits", mosiErr, 0);
          checkOutput("ss_busy_in_frame", glitch, 0);
          checkOutput("rd_data", 32'(rd_data), 32'(sb[0].rdExp));
          checkOutput("ss_released", 32'(SS_n), 1);
          checkOutput("busy_at_done", 32'(busy), 1);
          void'(sb.pop_front());
          mosiErr = 0;
          glitch  = 0;
        end
      end else if (sb.size() > 0 && k > len + 4) begin
        checkOutput("done_timeout", k, len);
        void'(sb.pop_front());
        mosiErr = 0;
        glitch  = 0;
      end
    end
  end

  task automatic pushExpected(input logic [1:0] c, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
    frame_t f;
    f.accept = cycle;
    f.c = c;
    f.d = d;
    if (c == 2'b11) modelRd = m;
    f.rdExp = modelRd;
    stubActive = (c == 2'b11);
    stubAccept = cycle;
    stubByte = m;
    sb.push_back(f);
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b0) checkOutput("idle_timeout", 32'(busy), 0);
  endtask

  // Issues one request from IDLE; returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic [1:0] c, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
    waitIdle();
    start = 1'b1;
    cmd = c;
    data_in = d;
    @(posedge clk);
    #1;
    pushExpected(c, d, m);
    @(negedge clk);
    start = 1'b0;
    cmd = 2'($urandom);
    data_in = DATA_W'($urandom);
  endtask

  task automatic waitDone();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      checkOutput("scoreboard_drain", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cmd = 2'b00;
    data_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ss_n", 32'(SS_n), 1);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_mosi", 32'(MOSI), 0);
    checkOutput("reset_rd_data", 32'(rd_data), 0);
    rst_n = 1'b1;

    // Directed frames: write address, write data, read address, read data, stub byte B2.
    applyStimulus(2'b00, 8'hFF, 8'h00); waitDone();
    applyStimulus(2'b01, 8'hA5, 8'h00); waitDone();
    applyStimulus(2'b10, 8'hFF, 8'h00); waitDone();
    applyStimulus(2'b11, 8'h00, 8'hA5); waitDone();
    applyStimulus(2'b11, 8'h3C, 8'hB2); waitDone();

    // Starts while busy and in RELEASE are dropped; a start still high in IDLE is taken.
    applyStimulus(2'b00, 8'h5A, 8'h00);
    repeat (2) @(negedge clk);
    start = 1'b1;
    cmd = 2'b11;
    data_in = 8'hC3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    cmd = 2'b11;
    data_in = 8'h96;
    @(posedge clk);
    @(posedge clk);
    #1;
    pushExpected(2'b11, 8'h96, 8'h6D);
    @(negedge clk);
    start = 1'b0;
    waitDone();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(2'($urandom), DATA_W'($urandom), DATA_W'($urandom));
      waitDone();
    end

    // Asynchronous reset in the middle of SHIFT while MOSI is high.
    applyStimulus(2'b00, 8'hFF, 8'h00);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    stubActive = 1'b0;
    modelRd = '0;
    #1;
    checkOutput("midreset_ss_n", 32'(SS_n), 1);
    checkOutput("midreset_busy", 32'(busy), 0);
    checkOutput("midreset_mosi", 32'(MOSI), 0);
    checkOutput("midreset_done", 32'(done), 0);
    checkOutput("midreset_rd_data", 32'(rd_data), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(2'b11, 8'h11, 8'hE7); waitDone();
    applyStimulus(2'b01, 8'h42, 8'h00); waitDone();

    repeat (5) @(negedge clk);
    checkOutput("final_idle_busy", 32'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
